// File: rtl/adaptive_sleep_controller.sv
// adaptive_sleep_controller
//
// Per-peripheral sleep sequencer. Each channel counts idle cycles and, once
// the count reaches an adaptive threshold, runs a four-phase
// sleep_req/sleep_ack handshake with the power-gating controller. A
// per-channel penalty raises the threshold after premature wakes and decays
// it after long sleeps.
//
// Ports:
//   clk                clock
//   rst_n              asynchronous active-low reset
//   en_i               global enable; 0 blocks new sleep requests
//   learn_en_i         1 = penalty registers update, 0 = frozen
//   activity_i[N]      per-channel activity strobe
//   base_th_i[N*W]     per-channel base idle threshold
//   alpha_i[4]         penalty step shift (step = base_th >> alpha, min 1)
//   sleep_ack_i[N]     per-channel acknowledge from the power controller
//   sleep_req_o[N]     per-channel sleep request (REQ or SLEEP)
//   asleep_o[N]        1 while the channel is in SLEEP
//   cur_th_o[N*W]      effective threshold = sat(base_th + pen)
//   premature_wake_o[N] one-cycle pulse after a penalty increment
//
// States (per channel):
//   state  | meaning
//   ACTIVE | counting idle cycles, no request
//   REQ    | sleep_req high, waiting for ack or abort
//   SLEEP  | acknowledged, counting sleep cycles
//   WAKE   | request withdrawn, waiting for ack to drop

module adaptive_sleep_controller #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           learn_en_i,
    input  logic [N-1:0]   activity_i,
    input  logic [N*W-1:0] base_th_i,
    input  logic [3:0]     alpha_i,
    input  logic [N-1:0]   sleep_ack_i,
    output logic [N-1:0]   sleep_req_o,
    output logic [N-1:0]   asleep_o,
    output logic [N*W-1:0] cur_th_o,
    output logic [N-1:0]   premature_wake_o
);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        REQ    = 2'd1,
        SLEEP  = 2'd2,
        WAKE   = 2'd3
    } state_t;

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t         state_q;
        logic [W-1:0]   idle_cnt_q;
        logic [W-1:0]   sleep_cnt_q;
        logic [W-1:0]   pen_q;
        logic           pw_q;

        logic [W-1:0]   base_d;
        logic [W:0]     th_sum_d;
        logic [W-1:0]   th_d;
        logic [W-1:0]   shr_d;
        logic [W-1:0]   step_d;
        logic [W:0]     pen_sum_d;
        logic [W-1:0]   pen_inc_d;

        assign base_d    = base_th_i[g*W +: W];

        // Sum on W+1 bits so an overflow shows up in the carry and clamps.
        assign th_sum_d  = {1'b0, base_d} + {1'b0, pen_q};
        assign th_d      = th_sum_d[W] ? {W{1'b1}} : th_sum_d[W-1:0];

        // A shift of W or more yields 0, which the floor below turns into 1.
        assign shr_d     = base_d >> alpha_i;
        assign step_d    = (shr_d == '0) ? {{(W-1){1'b0}}, 1'b1} : shr_d;
        assign pen_sum_d = {1'b0, pen_q} + {1'b0, step_d};
        assign pen_inc_d = pen_sum_d[W] ? {W{1'b1}} : pen_sum_d[W-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= ACTIVE;
                idle_cnt_q  <= '0;
                sleep_cnt_q <= '0;
                pen_q       <= '0;
                pw_q        <= 1'b0;
            end else begin
                pw_q <= 1'b0;
                case (state_q)
                    ACTIVE: begin
                        if (activity_i[g]) begin
                            idle_cnt_q <= '0;
                        end else if (en_i && (idle_cnt_q >= th_d)) begin
                            state_q    <= REQ;
                            idle_cnt_q <= '0;
                        end else if (idle_cnt_q != {W{1'b1}}) begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                    REQ: begin
                        idle_cnt_q <= '0;
                        // Activity takes priority over an arriving ack.
                        if (activity_i[g]) begin
                            state_q <= sleep_ack_i[g] ? WAKE : ACTIVE;
                        end else if (sleep_ack_i[g]) begin
                            state_q     <= SLEEP;
                            sleep_cnt_q <= '0;
                        end
                    end
                    SLEEP: begin
                        idle_cnt_q <= '0;
                        if (sleep_cnt_q != {W{1'b1}}) begin
                            sleep_cnt_q <= sleep_cnt_q + 1'b1;
                        end
                        // Ack withdrawal is a controller-initiated wake and
                        // learns exactly like a peripheral-initiated one.
                        if (activity_i[g] || !sleep_ack_i[g]) begin
                            state_q <= WAKE;
                            if (learn_en_i) begin
                                if (sleep_cnt_q < base_d) begin
                                    pen_q <= pen_inc_d;
                                    pw_q  <= 1'b1;
                                end else begin
                                    pen_q <= pen_q >> 1;
                                end
                            end
                        end
                    end
                    WAKE: begin
                        idle_cnt_q <= '0;
                        if (!sleep_ack_i[g]) begin
                            state_q <= ACTIVE;
                        end
                    end
                    default: state_q <= ACTIVE;
                endcase
            end
        end

        assign sleep_req_o[g]      = (state_q == REQ) || (state_q == SLEEP);
        assign asleep_o[g]         = (state_q == SLEEP);
        assign premature_wake_o[g] = pw_q;
        assign cur_th_o[g*W +: W]  = th_d;
    end

endmodule

// File: tb/tb_adaptive_sleep_controller.sv
module tb_adaptive_sleep_controller;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           learn_en;
    logic [N-1:0]   activity;
    logic [N*W-1:0] base_th;
    logic [3:0]     alpha;
    logic [N-1:0]   sleep_ack;
    logic [N-1:0]   sleep_req;
    logic [N-1:0]   asleep;
    logic [N*W-1:0] cur_th;
    logic [N-1:0]   premature_wake;

    adaptive_sleep_controller #(.N(N), .W(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_i             (en),
        .learn_en_i       (learn_en),
        .activity_i       (activity),
        .base_th_i        (base_th),
        .alpha_i          (alpha),
        .sleep_ack_i      (sleep_ack),
        .sleep_req_o      (sleep_req),
        .asleep_o         (asleep),
        .cur_th_o         (cur_th),
        .premature_wake_o (premature_wake)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_base(input int ch, input logic [W-1:0] v);
        base_th[ch*W +: W] = v;
    endtask

    function automatic logic [31:0] th_of(input int ch);
        return {16'h0, cur_th[ch*W +: W]};
    endfunction

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        learn_en  = 1'b0;
        alpha     = 4'd2;
        activity  = '1;
        sleep_ack = '0;
        for (int i = 0; i < N; i++) set_base(i, 16'd10);
        #12;

        // Reset state
        push("rst_req", 0);      pop_chk(sleep_req);
        push("rst_asleep", 0);   pop_chk(asleep);
        push("rst_pw", 0);       pop_chk(premature_wake);
        push("rst_th0", 10);     pop_chk(th_of(0));
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Scenario 1: threshold 10 -> request on idle edge 11
        activity[0] = 1'b0;
        push("s1_req_edge10", 0); cyc(10); pop_chk(sleep_req[0]);
        push("s1_req_edge11", 1); cyc(1);  pop_chk(sleep_req[0]);
        push("s1_req_hold", 1);   cyc(3);  pop_chk(sleep_req[0]);
        push("s1_not_asleep", 0); pop_chk(asleep[0]);
        sleep_ack[0] = 1'b1;
        push("s1_asleep", 1);     cyc(1);  pop_chk(asleep[0]);

        // Premature wake with learning frozen: no pulse, threshold unchanged
        activity[0] = 1'b1;
        push("s5_nolearn_pw", 0);  cyc(1); pop_chk(premature_wake[0]);
        push("s5_nolearn_th", 10); pop_chk(th_of(0));
        push("wake_req_low", 0);   pop_chk(sleep_req[0]);
        sleep_ack[0] = 1'b0;
        cyc(1);

        // Scenario 2: abort from REQ, counter restarts from 0
        activity[0] = 1'b0;
        push("s2_req_a", 0);  cyc(10); pop_chk(sleep_req[0]);
        push("s2_req_b", 1);  cyc(1);  pop_chk(sleep_req[0]);
        activity[0] = 1'b1;
        push("s2_abort", 0);  cyc(1);  pop_chk(sleep_req[0]);
        activity[0] = 1'b0;
        push("s2_reidle_10", 0); cyc(10); pop_chk(sleep_req[0]);
        push("s2_reidle_11", 1); cyc(1);  pop_chk(sleep_req[0]);
        // Activity with ack together goes to WAKE, which ignores idleness
        activity[0] = 1'b1;
        sleep_ack[0] = 1'b1;
        push("s2_wake_req", 0);   cyc(1);  pop_chk(sleep_req[0]);
        push("s2_wake_asleep", 0); pop_chk(asleep[0]);
        activity[0] = 1'b0;
        push("s2_wake_hold", 0);  cyc(15); pop_chk(sleep_req[0]);
        sleep_ack[0] = 1'b0;
        cyc(1);
        push("s2_active_10", 0);  cyc(10); pop_chk(sleep_req[0]);
        push("s2_active_11", 1);  cyc(1);  pop_chk(sleep_req[0]);
        activity[0] = 1'b1;
        cyc(1);

        // Scenario 3: learning with base 16, alpha 2 (step 4)
        learn_en = 1'b1;
        set_base(0, 16'd16);
        #1;
        push("s3_th16", 16);   pop_chk(th_of(0));
        activity[0] = 1'b0;
        push("s3_req_a0", 0);  cyc(16); pop_chk(sleep_req[0]);
        push("s3_req_a1", 1);  cyc(1);  pop_chk(sleep_req[0]);
        sleep_ack[0] = 1'b1;
        cyc(1); cyc(4);
        activity[0] = 1'b1;
        push("s3_pw_a", 1);    cyc(1); pop_chk(premature_wake[0]);
        push("s3_th20", 20);   pop_chk(th_of(0));
        push("s3_pw_a_end", 0); cyc(1); pop_chk(premature_wake[0]);
        sleep_ack[0] = 1'b0;
        cyc(1);
        activity[0] = 1'b0;
        push("s3_req_b0", 0);  cyc(20); pop_chk(sleep_req[0]);
        push("s3_req_b1", 1);  cyc(1);  pop_chk(sleep_req[0]);
        sleep_ack[0] = 1'b1;
        cyc(1); cyc(4);
        activity[0] = 1'b1;
        push("s3_pw_b", 1);    cyc(1); pop_chk(premature_wake[0]);
        push("s3_th24", 24);   pop_chk(th_of(0));
        sleep_ack[0] = 1'b0;
        cyc(1);
        activity[0] = 1'b0;
        push("s3_req_c0", 0);  cyc(24); pop_chk(sleep_req[0]);
        push("s3_req_c1", 1);  cyc(1);  pop_chk(sleep_req[0]);
        sleep_ack[0] = 1'b1;
        cyc(1); cyc(40);
        activity[0] = 1'b1;
        push("s3_long_pw", 0); cyc(1); pop_chk(premature_wake[0]);
        push("s3_decay_th20", 20); pop_chk(th_of(0));
        sleep_ack[0] = 1'b0;
        cyc(1);

        // Scenario 5: learn_en=0 with pen nonzero, then en gating
        learn_en = 1'b0;
        activity[0] = 1'b0;
        push("s5_req", 1);     cyc(21); pop_chk(sleep_req[0]);
        sleep_ack[0] = 1'b1;
        cyc(1); cyc(2);
        activity[0] = 1'b1;
        push("s5_pw", 0);      cyc(1); pop_chk(premature_wake[0]);
        push("s5_th", 20);     pop_chk(th_of(0));
        sleep_ack[0] = 1'b0;
        cyc(1);
        learn_en = 1'b1;
        en = 1'b0;
        activity[0] = 1'b0;
        push("s5_en0_noreq", 0); cyc(30); pop_chk(sleep_req[0]);
        en = 1'b1;
        push("s5_en1_req", 1);   cyc(1);  pop_chk(sleep_req[0]);
        en = 1'b0;
        push("s5_en_fall_hold", 1); cyc(3); pop_chk(sleep_req[0]);
        en = 1'b1;
        activity[0] = 1'b1;
        cyc(1);

        // Scenario 6: reset mid-SLEEP with ack high
        activity[0] = 1'b0;
        push("s6_req", 1);     cyc(21); pop_chk(sleep_req[0]);
        sleep_ack[0] = 1'b1;
        push("s6_asleep", 1);  cyc(1);  pop_chk(asleep[0]);
        #2;
        rst_n = 1'b0;
        #1;
        push("s6_rst_req", 0);    pop_chk(sleep_req);
        push("s6_rst_asleep", 0); pop_chk(asleep);
        push("s6_rst_pw", 0);     pop_chk(premature_wake);
        push("s6_rst_pen0", 16);  pop_chk(th_of(0));
        activity  = '1;
        sleep_ack = '0;
        cyc(2);
        rst_n = 1'b1;
        set_base(0, 16'd10);
        set_base(2, 16'd5);
        activity[0] = 1'b0;
        activity[2] = 1'b0;
        push("s6_req_e5", 4'b0000);  cyc(5); pop_chk(sleep_req);
        push("s6_req_e6", 4'b0100);  cyc(1); pop_chk(sleep_req);
        push("s6_req_e10", 4'b0100); cyc(4); pop_chk(sleep_req);
        push("s6_req_e11", 4'b0101); cyc(1); pop_chk(sleep_req);
        sleep_ack[2] = 1'b1;
        push("s6_asleep2", 4'b0100); cyc(1); pop_chk(asleep);
        activity = '1;
        push("s6_pw2", 4'b0100);     cyc(1); pop_chk(premature_wake);
        push("s6_req_none", 4'b0000); pop_chk(sleep_req);
        push("s6_th2", 6);           pop_chk(th_of(2));
        push("s6_th0", 10);          pop_chk(th_of(0));
        sleep_ack = '0;
        cyc(1);

        // Scenario 4: saturation of threshold and idle counter on channel 1
        set_base(1, 16'd2);
        activity[1] = 1'b0;
        push("s4_req_fast", 1); cyc(3); pop_chk(sleep_req[1]);
        sleep_ack[1] = 1'b1;
        push("s4_asleep", 1);   cyc(1); pop_chk(asleep[1]);
        set_base(1, 16'hFFF0);
        alpha = 4'd0;
        activity[1] = 1'b1;
        push("s4_pw", 1);       cyc(1); pop_chk(premature_wake[1]);
        push("s4_th_sat", 32'hFFFF); pop_chk(th_of(1));
        sleep_ack[1] = 1'b0;
        cyc(1);
        activity[1] = 1'b0;
        push("s4_idle_sat_pre", 0); cyc(65535); pop_chk(sleep_req[1]);
        push("s4_idle_sat_req", 1); cyc(1);     pop_chk(sleep_req[1]);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adaptive_sleep_controller.md
Name: adaptive_sleep_controller

Overview:
Per-peripheral sleep sequencer. It counts idle cycles internally and compares the count against a threshold that adapts by learning. When the count reaches the threshold, it runs a four-phase sleep_req/sleep_ack handshake with the power controller. A per-channel penalty register raises the threshold after premature wakes and decays it after long sleeps. It sits between peripheral activity monitors and the SoC power-gating controller.

Parameters:
N, 4, number of peripheral channels
W, 16, width of the idle counter, sleep counter, threshold and penalty (bits)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  global enable; 0 blocks new sleep requests
learn_en  input  1  1 = penalty register updates; 0 = penalty frozen
activity  input  N  per-channel activity strobe, sampled every cycle
base_th  input  N*W  per-channel programmable base idle threshold
alpha  input  4  penalty step shift
sleep_ack  input  N  per-channel acknowledge from the power controller
sleep_req  output  N  per-channel sleep request, decoded from the state register
asleep  output  N  1 while the channel is in SLEEP
cur_th  output  N*W  current effective threshold per channel
premature_wake  output  N  one-cycle pulse on the edge where the penalty is incremented

Behaviour:
- Reset values: state=ACTIVE, idle_cnt=0, sleep_cnt=0, pen=0. All outputs are 0; cur_th=base_th.
- Threshold: th = saturate_W(base_th + pen), computed on W+1 bits and clamped to all-ones on overflow. It is combinational, and cur_th=th.
- Step: step = base_th>>alpha, forced to 1 if the result is 0. alpha>=W gives step=1.
- Channels are fully independent. The only shared inputs are en, learn_en and alpha.
- idle_cnt in ACTIVE:
  - activity=1 -> 0.
  - otherwise saturating +1; it holds at all-ones and never wraps.
  - In every other state idle_cnt is held at 0.
- FSM per channel, 2-bit, states ACTIVE / REQ / SLEEP / WAKE:
  - ACTIVE->REQ when en=1, activity=0 and registered idle_cnt>=th. With th=10 and idle starting at idle_cnt=0, idle_cnt=10 after 10 idle edges, and REQ is entered on edge 11. th=0 enters REQ on the first idle edge.
  - REQ: sleep_req=1.
    - activity=1 and sleep_ack=0 -> ACTIVE (abort; idle_cnt=0).
    - activity=1 and sleep_ack=1 -> WAKE (activity wins over ack).
    - activity=0 and sleep_ack=1 -> SLEEP; sleep_cnt=0.
    - Otherwise stay in REQ indefinitely. There is no timeout.
    - en falling while in REQ does not abort.
  - SLEEP: sleep_req=1, asleep=1. sleep_cnt is saturating +1 per cycle.
    - activity=1 -> WAKE and apply the learning update on the same edge.
    - sleep_ack dropping with no activity -> WAKE; this is treated as a controller-initiated wake and gets the same learning update.
  - WAKE: sleep_req=0. Go to ACTIVE on the first edge with sleep_ack=0. Activity in WAKE is ignored.
- Learning update, on the SLEEP->WAKE edge and only if learn_en=1:
  - If sleep_cnt < base_th: pen = saturate_W(pen + step) and premature_wake pulses high for the following cycle.
  - Else: pen = pen>>1.
  - learn_en=0 leaves pen unchanged and produces no pulse.
- base_th changes take effect on th in the same cycle. pen is not cleared by a base_th change, only by reset.
- Reset mid-handshake: sleep_req drops asynchronously and the FSM returns to ACTIVE. The power controller must tolerate req withdrawal while ack is high.
- All state is clocked on posedge clk. All outputs are registered or decoded directly from registers, so there are no combinational input-to-output paths apart from cur_th, which depends on base_th.

Test Plan:
1. base_th=10, pen=0, en=1, activity low from cycle 0 -> sleep_req rises after edge 11. ack raised 3 cycles later -> asleep=1 on the following edge.
2. Same setup, activity pulse while in REQ with ack=0 -> sleep_req low next cycle and idle_cnt=0. With ack=1 at the same time -> WAKE, then ACTIVE after ack drops.
3. base_th=16, alpha=2, learn_en=1: sleep for 5 cycles, then activity -> premature_wake pulses, pen=4, cur_th=20. Repeat -> pen=8, cur_th=24. Then a 40-cycle sleep -> pen=4.
4. base_th=0xFFF0, pen driven high by repeated premature wakes -> cur_th saturates at 0xFFFF. idle_cnt saturates at 0xFFFF, so REQ is still reached.
5. learn_en=0 with a premature wake -> pen unchanged, no pulse. en=0 with idle_cnt>th -> no request; raising en -> REQ on the next edge.
6. rst_n asserted mid-SLEEP with ack=1 -> all outputs 0 immediately, pen=0. After release, the channel behaves per scenario 1 independently of other channels.
